// File: rtl/beep_req_arbiter_pkg.sv
// Shared types, widths and default pattern tables for the beeper arbiter.
package beep_req_arbiter_pkg;

  localparam int unsigned MS_W      = 16;
  localparam int unsigned REP_W     = 4;
  localparam int unsigned N_REQ_DEF = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  // Channel 0 sits in the LSBs: ch0 = error, ch1 = alarm, ch2 = key click.
  localparam logic [N_REQ_DEF*MS_W-1:0]  ON_MS_DEF  = {16'd50, 16'd500, 16'd100};
  localparam logic [N_REQ_DEF*MS_W-1:0]  OFF_MS_DEF = {16'd50, 16'd250, 16'd100};
  localparam logic [N_REQ_DEF*REP_W-1:0] REPS_DEF   = {4'd1, 4'd2, 4'd3};

  // Last ms index of a phase; a zero-length phase is stretched to 1 ms.
  function automatic logic [MS_W-1:0] ms_last(input logic [MS_W-1:0] ms);
    return (ms == '0) ? '0 : ms - MS_W'(1);
  endfunction

  // Effective repetition count; zero plays the pattern once.
  function automatic logic [REP_W-1:0] rep_count(input logic [REP_W-1:0] r);
    return (r == '0) ? REP_W'(1) : r;
  endfunction

endpackage

// File: rtl/beep_req_arbiter_if.sv
// Request/status bundle between the event logic and the beeper arbiter.
interface beep_req_arbiter_if
  import beep_req_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF
);
  logic [N_REQ-1:0] req;
  logic             beep;
  logic             busy;
  logic [N_REQ-1:0] grant;
  logic             done;
  logic             aborted;

  modport master (output req, input beep, busy, grant, done, aborted);
  modport slave  (input req, output beep, busy, grant, done, aborted);
endinterface

// File: rtl/beep_req_arbiter_ms_tick.sv
// Millisecond prescaler: counts 0..CNT_1MS-1 and flags the wrap cycle.
module beep_req_arbiter_ms_tick #(
  parameter int unsigned CNT_1MS = 50000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic clr,
  output logic tick_c
);
  localparam int unsigned PW = (CNT_1MS > 1) ? $clog2(CNT_1MS) : 1;

  logic [PW-1:0] presc;

  assign tick_c = (presc == PW'(CNT_1MS - 1));

  // Free-running prescaler, held at zero while clr is asserted.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clr) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end
endmodule

// File: rtl/beep_req_arbiter.sv
// Fixed-priority arbiter sharing one beeper between N_REQ pattern sources.
// Optional feature macro: BEEP_PREEMPT_EN (higher-priority request aborts
// the pattern in service; without it every pattern runs to completion).
module beep_req_arbiter
  import beep_req_arbiter_pkg::*;
#(
  parameter int unsigned               CNT_1MS    = 50000,
  parameter int unsigned               N_REQ      = N_REQ_DEF,
  parameter logic [N_REQ*MS_W-1:0]     ON_MS_TBL  = ON_MS_DEF,
  parameter logic [N_REQ*MS_W-1:0]     OFF_MS_TBL = OFF_MS_DEF,
  parameter logic [N_REQ*REP_W-1:0]    REPS_TBL   = REPS_DEF
) (
  input logic               sys_clk,
  input logic               sys_rst,
  beep_req_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t             state;
  logic [N_REQ-1:0]   pending;
  logic [N_REQ-1:0]   grant_q;
  logic [N_REQ-1:0]   pick_oh_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [IDX_W-1:0]   cur_idx;
  logic [MS_W-1:0]    ms_cnt;
  logic [MS_W-1:0]    on_last_c;
  logic [MS_W-1:0]    off_last_c;
  logic [REP_W-1:0]   rep;
  logic [REP_W-1:0]   reps_c;
  logic               last_rep_c;
  logic               beep_q;
  logic               busy_q;
  logic               done_q;
  logic               tick_c;
  logic               ms_clr_c;
  logic               preempt_c;

  assign ms_clr_c = (state == S_IDLE);

  beep_req_arbiter_ms_tick #(
    .CNT_1MS (CNT_1MS)
  ) u_ms_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clr     (ms_clr_c),
    .tick_c  (tick_c)
  );

  // Lowest-index pending request wins.
  always_comb begin
    pick_idx_c = '0;
    pick_oh_c  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_idx_c = IDX_W'(i);
        pick_oh_c  = N_REQ'(1) << i;
      end
    end
  end

  // Pattern parameters of the channel in service.
  always_comb begin
    on_last_c  = '0;
    off_last_c = '0;
    reps_c     = REP_W'(1);
    for (int i = 0; i < N_REQ; i++) begin
      if (cur_idx == IDX_W'(i)) begin
        on_last_c  = ms_last(ON_MS_TBL[i*MS_W +: MS_W]);
        off_last_c = ms_last(OFF_MS_TBL[i*MS_W +: MS_W]);
        reps_c     = rep_count(REPS_TBL[i*REP_W +: REP_W]);
      end
    end
  end

  assign last_rep_c = ((REP_W+1)'(rep) + (REP_W+1)'(1)) >= (REP_W+1)'(reps_c);

`ifdef BEEP_PREEMPT_EN
  logic aborted_q;

  // A pending request of higher priority than the one in service.
  always_comb begin
    preempt_c = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if ((IDX_W'(i) < cur_idx) && pending[i]) begin
        preempt_c = 1'b1;
      end
    end
    if (state == S_IDLE) begin
      preempt_c = 1'b0;
    end
  end

  // One-cycle abort pulse, coincident with the return to IDLE.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      aborted_q <= 1'b0;
    end else begin
      aborted_q <= preempt_c;
    end
  end

  assign bus.aborted = aborted_q;
`else
  assign preempt_c   = 1'b0;
  assign bus.aborted = 1'b0;
`endif

  // Request latching, grant selection and ON/OFF pattern sequencing.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= S_IDLE;
      pending <= '0;
      grant_q <= '0;
      cur_idx <= '0;
      ms_cnt  <= '0;
      rep     <= '0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      pending <= pending | bus.req;
      case (state)
        S_IDLE: begin
          if (|pending) begin
            state   <= S_ON;
            cur_idx <= pick_idx_c;
            grant_q <= pick_oh_c;
            pending <= (pending & ~pick_oh_c) | bus.req;
            ms_cnt  <= '0;
            rep     <= '0;
            beep_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_ON: begin
          if (preempt_c) begin
            state   <= S_IDLE;
            grant_q <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick_c) begin
            if (ms_cnt == on_last_c) begin
              state  <= S_OFF;
              beep_q <= 1'b0;
              ms_cnt <= '0;
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        S_OFF: begin
          if (preempt_c) begin
            state   <= S_IDLE;
            grant_q <= '0;
            beep_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (tick_c) begin
            if (ms_cnt == off_last_c) begin
              ms_cnt <= '0;
              if (!last_rep_c) begin
                state  <= S_ON;
                rep    <= rep + REP_W'(1);
                beep_q <= 1'b1;
              end else begin
                state   <= S_IDLE;
                grant_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              ms_cnt <= ms_cnt + MS_W'(1);
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          grant_q <= '0;
          beep_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.beep  = beep_q;
  assign bus.busy  = busy_q;
  assign bus.grant = grant_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_beep_req_arbiter.sv
// Directed scenarios plus random request traffic against a timeline model.
module tb_beep_req_arbiter;
  localparam int unsigned CNT = 10;
  localparam int unsigned NR  = 3;
  localparam int ON_MS   [NR] = '{100, 500, 50};
  localparam int OFF_MS  [NR] = '{100, 250, 50};
  localparam int REPS    [NR] = '{3, 2, 1};
`ifdef BEEP_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst;

  always #5 sys_clk = ~sys_clk;

  beep_req_arbiter_if #(.N_REQ(NR)) bus ();

  beep_req_arbiter #(
    .CNT_1MS    (CNT),
    .N_REQ      (NR),
    .ON_MS_TBL  ({16'd50, 16'd500, 16'd100}),
    .OFF_MS_TBL ({16'd50, 16'd250, 16'd100}),
    .REPS_TBL   ({4'd1, 4'd2, 4'd3})
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: pending set plus the start cycle of the job in service.
  logic [NR-1:0] m_pend = '0;
  bit            m_act  = 1'b0;
  int            m_ch   = 0;
  int            m_s    = 0;
  int            cyc    = 0;
  bit            e_done;
  bit            e_abort;

  int            done_seen    = 0;
  int            aborted_seen = 0;
  logic [NR-1:0] prev_grant   = '0;
  logic [NR-1:0] grant_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int on_cyc(input int k);
    return ((ON_MS[k] == 0) ? 1 : ON_MS[k]) * CNT;
  endfunction

  function automatic int off_cyc(input int k);
    return ((OFF_MS[k] == 0) ? 1 : OFF_MS[k]) * CNT;
  endfunction

  function automatic int total_cyc(input int k);
    return ((REPS[k] == 0) ? 1 : REPS[k]) * (on_cyc(k) + off_cyc(k));
  endfunction

  // Advance the model across one clock edge.
  task automatic model_edge(input logic [NR-1:0] r, input bit rst);
    bit higher;
    cyc++;
    e_done  = 1'b0;
    e_abort = 1'b0;
    if (rst) begin
      m_pend = '0;
      m_act  = 1'b0;
    end else if (m_act) begin
      higher = 1'b0;
      for (int j = 0; j < m_ch; j++) if (m_pend[j]) higher = 1'b1;
      if (PRE && higher) begin
        m_act   = 1'b0;
        e_abort = 1'b1;
      end else if (cyc == m_s + total_cyc(m_ch)) begin
        m_act  = 1'b0;
        e_done = 1'b1;
      end
      m_pend = m_pend | r;
    end else if (m_pend != '0) begin
      m_ch = 0;
      while (!m_pend[m_ch]) m_ch++;
      m_act  = 1'b1;
      m_s    = cyc;
      m_pend[m_ch] = 1'b0;
      m_pend = m_pend | r;
    end else begin
      m_pend = m_pend | r;
    end
  endtask

  task automatic step(input logic [NR-1:0] r, input bit rst);
    logic       e_beep;
    logic [NR-1:0] e_grant;
    bus.req = r;
    sys_rst = rst;
    @(posedge sys_clk);
    model_edge(r, rst);
    #1;
    e_beep  = m_act && (((cyc - m_s) % (on_cyc(m_ch) + off_cyc(m_ch))) < on_cyc(m_ch));
    e_grant = m_act ? NR'(1 << m_ch) : '0;
    check("outs{beep,busy,grant,done,aborted}",
          32'({bus.beep, bus.busy, bus.grant, bus.done, bus.aborted}),
          32'({e_beep, m_act, e_grant, e_done, e_abort}));
    if (bus.done) done_seen++;
    if (bus.aborted) aborted_seen++;
    if (bus.grant != '0 && prev_grant == '0) grant_log.push_back(bus.grant);
    prev_grant = bus.grant;
    bus.req = '0;
    sys_rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0);
  endtask

  task automatic clear_log();
    grant_log.delete();
    done_seen    = 0;
    aborted_seen = 0;
  endtask

  initial begin
    bus.req = '0;
    sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) step('0, 1'b1);

    // Idle after reset: nothing happens.
    idle(100);
    check("t1_done", 32'(done_seen), 32'd0);

    // Single ch0 request: two-cycle latency, 3x(1000/1000), one done.
    clear_log();
    step(3'b001, 1'b0);
    check("t2_lat1_beep", 32'(bus.beep), 32'd0);
    step('0, 1'b0);
    check("t2_lat2_beep", 32'(bus.beep), 32'd1);
    check("t2_grant", 32'(bus.grant), 32'b001);
    idle(6100);
    check("t2_done", 32'(done_seen), 32'd1);

    // All three at once: served in index order.
    clear_log();
    step(3'b111, 1'b0);
    idle(22100);
    check("t3_done", 32'(done_seen), 32'd3);
    check("t3_ngrant", 32'(grant_log.size()), 32'd3);
    check("t3_g0", 32'(grant_log[0]), 32'b001);
    check("t3_g1", 32'(grant_log[1]), 32'b010);
    check("t3_g2", 32'(grant_log[2]), 32'b100);

    // Repeated ch2 requests during ch2 service merge into one re-run.
    clear_log();
    step(3'b100, 1'b0);
    idle(100);
    step(3'b100, 1'b0);
    idle(50);
    step(3'b100, 1'b0);
    idle(50);
    step(3'b100, 1'b0);
    idle(2200);
    check("t4_ngrant", 32'(grant_log.size()), 32'd2);
    check("t4_done", 32'(done_seen), 32'd2);

    // Reset mid ch1 ON with ch2 pending: everything is dropped.
    clear_log();
    step(3'b010, 1'b0);
    idle(1000);
    step(3'b100, 1'b0);
    idle(1000);
    check("t5_on_beep", 32'(bus.beep), 32'd1);
    step('0, 1'b1);
    check("t5_rst_beep", 32'(bus.beep), 32'd0);
    check("t5_rst_grant", 32'(bus.grant), 32'd0);
    idle(3000);
    check("t5_done", 32'(done_seen), 32'd0);
    check("t5_ngrant", 32'(grant_log.size()), 32'd1);

    // ch0 request while ch2 is in service.
    clear_log();
    step(3'b100, 1'b0);
    idle(200);
    step(3'b001, 1'b0);
    idle(7200);
    check("t6_ngrant", 32'(grant_log.size()), 32'd2);
    check("t6_g0", 32'(grant_log[0]), 32'b100);
    check("t6_g1", 32'(grant_log[1]), 32'b001);
`ifdef BEEP_PREEMPT_EN
    check("t6_done", 32'(done_seen), 32'd1);
    check("t6_aborted", 32'(aborted_seen), 32'd1);
`else
    check("t6_done", 32'(done_seen), 32'd2);
    check("t6_aborted", 32'(aborted_seen), 32'd0);
`endif

    // Random sparse request pulses with occasional resets.
    for (int i = 0; i < 25000; i++) begin
      logic [NR-1:0] r;
      bit            rst;
      r   = ($urandom_range(0, 149) == 0) ? NR'($urandom) : '0;
      rst = ($urandom_range(0, 7999) == 0);
      step(r, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
